// File: rtl/ad7655_emulator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ad7655_emulator
//
// Synthesizable stand-in for the AD7655 dual-channel ADC. It answers the
// FPGA-side driver's conversion-start and read strobes the same way the real
// converter does. Each accepted start converts channel A and then channel B
// of the selected pair. n_BUSY is held low for the whole sequence, n_EOC is
// pulsed low once per channel, and results are returned on ADC_DATA.
//
// Parameters:
//   CONV_CYCLES  clocks per channel conversion (>= 1)
//   EOC_CYCLES   clocks n_EOC is held low per channel (>= 2)
//
// Optional build macro:
//   AD7655_EMU_RAMP_EN  samples come from four internal ramp counters instead
//                       of the INA1..INB2 ports.
//
// Ports:
//   Clk_100M        system clock, rising edge
//   n_RST           asynchronous active-low reset
//   n_CNVST         conversion start, falling edge, asynchronous input
//   A0              pair select, sampled when a start is accepted
//   AB_n            read select: 1 = channel A result, 0 = channel B result
//   n_CS, n_RD      chip select / read enable, active low
//   INA1..INB2      16-bit sample values
//   n_BUSY          low while a conversion sequence is running
//   n_EOC           low pulse per completed channel
//   ADC_DATA        registered read data
//   CNVST_IGNORED   one-clock pulse when a start edge is dropped
// ---------------------------------------------------------------------------
module ad7655_emulator #(
    parameter int CONV_CYCLES = 28,
    parameter int EOC_CYCLES  = 4
) (
    input  logic        Clk_100M,
    input  logic        n_RST,
    input  logic        n_CNVST,
    input  logic        A0,
    input  logic        AB_n,
    input  logic        n_CS,
    input  logic        n_RD,
    input  logic [15:0] INA1,
    input  logic [15:0] INB1,
    input  logic [15:0] INA2,
    input  logic [15:0] INB2,
    output logic        n_BUSY,
    output logic        n_EOC,
    output logic [15:0] ADC_DATA,
    output logic        CNVST_IGNORED
);

    localparam int MAX_CYCLES = (CONV_CYCLES > EOC_CYCLES) ? CONV_CYCLES : EOC_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] EOC_LAST  = CNT_W'(EOC_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV_A = 3'd1,
        EOC_A  = 3'd2,
        CONV_B = 3'd3,
        EOC_B  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;

    logic             cnvst_sync1_r;
    logic             cnvst_sync2_r;
    logic             start_edge_s;

    logic             capture_s;
    logic             load_a_s;
    logic             load_b_s;
    logic             ignore_s;

    logic [15:0]      sample_a_s;
    logic [15:0]      sample_b_s;
    logic [15:0]      hold_a_r;
    logic [15:0]      hold_b_r;
    logic [15:0]      res_a_r;
    logic [15:0]      res_b_r;

    logic             n_busy_r;
    logic             n_eoc_r;
    logic [15:0]      adc_data_r;
    logic             cnvst_ignored_r;

    // Two-flop synchronizer for the asynchronous start strobe. The flops reset
    // low, so an n_CNVST already held low when reset is released reads as
    // "was low, still low" and never as a falling edge.
    always_ff @(posedge Clk_100M or negedge n_RST) begin
        if (!n_RST) begin
            cnvst_sync1_r <= 1'b0;
            cnvst_sync2_r <= 1'b0;
        end else begin
            cnvst_sync1_r <= n_CNVST;
            cnvst_sync2_r <= cnvst_sync1_r;
        end
    end

    assign start_edge_s = cnvst_sync2_r & ~cnvst_sync1_r;

`ifdef AD7655_EMU_RAMP_EN
    logic [15:0] ramp_a1_r;
    logic [15:0] ramp_b1_r;
    logic [15:0] ramp_a2_r;
    logic [15:0] ramp_b2_r;

    // Ramp sources: the counters of the pair being captured advance by one,
    // so successive conversions on one pair read consecutive values.
    always_ff @(posedge Clk_100M or negedge n_RST) begin
        if (!n_RST) begin
            ramp_a1_r <= 16'h0000;
            ramp_b1_r <= 16'h4000;
            ramp_a2_r <= 16'h8000;
            ramp_b2_r <= 16'hC000;
        end else if (capture_s) begin
            if (A0) begin
                ramp_a2_r <= ramp_a2_r + 16'd1;
                ramp_b2_r <= ramp_b2_r + 16'd1;
            end else begin
                ramp_a1_r <= ramp_a1_r + 16'd1;
                ramp_b1_r <= ramp_b1_r + 16'd1;
            end
        end else begin
            ramp_a1_r <= ramp_a1_r;
            ramp_b1_r <= ramp_b1_r;
            ramp_a2_r <= ramp_a2_r;
            ramp_b2_r <= ramp_b2_r;
        end
    end

    // Sample selection from the ramp counters.
    always_comb begin
        sample_a_s = ramp_a1_r;
        sample_b_s = ramp_b1_r;
        if (A0) begin
            sample_a_s = ramp_a2_r;
            sample_b_s = ramp_b2_r;
        end else begin
            sample_a_s = ramp_a1_r;
            sample_b_s = ramp_b1_r;
        end
    end
`else
    // Sample selection from the input ports.
    always_comb begin
        sample_a_s = INA1;
        sample_b_s = INB1;
        if (A0) begin
            sample_a_s = INA2;
            sample_b_s = INB2;
        end else begin
            sample_a_s = INA1;
            sample_b_s = INB1;
        end
    end
`endif

    // State register and per-state cycle counter. The counter restarts at
    // zero on every state change, and is held at zero while idle.
    always_ff @(posedge Clk_100M or negedge n_RST) begin
        if (!n_RST) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            if ((state_next_s != state_r) || (state_r == IDLE)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state logic and the one-cycle strobes that move data around.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        load_a_s     = 1'b0;
        load_b_s     = 1'b0;
        // Only IDLE may accept a start. Anything seen elsewhere, including
        // the last EOC_B cycle, is dropped and never queued.
        ignore_s     = start_edge_s && (state_r != IDLE);
        case (state_r)
            IDLE: begin
                if (start_edge_s) begin
                    state_next_s = CONV_A;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CONV_A: begin
                if (cnt_r == CONV_LAST) begin
                    state_next_s = EOC_A;
                    load_a_s     = 1'b1;
                end else begin
                    state_next_s = CONV_A;
                end
            end
            EOC_A: begin
                if (cnt_r == EOC_LAST) begin
                    state_next_s = CONV_B;
                end else begin
                    state_next_s = EOC_A;
                end
            end
            CONV_B: begin
                if (cnt_r == CONV_LAST) begin
                    state_next_s = EOC_B;
                    load_b_s     = 1'b1;
                end else begin
                    state_next_s = CONV_B;
                end
            end
            EOC_B: begin
                if (cnt_r == EOC_LAST) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = EOC_B;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Hold registers are written when a start is accepted. A0 takes effect
    // only here, so later changes to A0 or the sample inputs cannot disturb
    // the conversion.
    always_ff @(posedge Clk_100M or negedge n_RST) begin
        if (!n_RST) begin
            hold_a_r <= 16'h0000;
            hold_b_r <= 16'h0000;
        end else if (capture_s) begin
            hold_a_r <= sample_a_s;
            hold_b_r <= sample_b_s;
        end else begin
            hold_a_r <= hold_a_r;
            hold_b_r <= hold_b_r;
        end
    end

    // Result registers. Each one loads on the edge that enters its EOC
    // state, so it is valid in the first cycle that n_EOC is low.
    always_ff @(posedge Clk_100M or negedge n_RST) begin
        if (!n_RST) begin
            res_a_r <= 16'h0000;
            res_b_r <= 16'h0000;
        end else begin
            if (load_a_s) begin
                res_a_r <= hold_a_r;
            end else begin
                res_a_r <= res_a_r;
            end
            if (load_b_s) begin
                res_b_r <= hold_b_r;
            end else begin
                res_b_r <= res_b_r;
            end
        end
    end

    // Status outputs are decoded from the next state, so they change on the
    // same edge as the state itself.
    always_ff @(posedge Clk_100M or negedge n_RST) begin
        if (!n_RST) begin
            n_busy_r        <= 1'b1;
            n_eoc_r         <= 1'b1;
            cnvst_ignored_r <= 1'b0;
        end else begin
            n_busy_r        <= (state_next_s == IDLE);
            n_eoc_r         <= !((state_next_s == EOC_A) || (state_next_s == EOC_B));
            cnvst_ignored_r <= ignore_s;
        end
    end

    // Read port: one clock of latency from n_CS, n_RD and AB_n. The bus reads
    // zero when not selected.
    always_ff @(posedge Clk_100M or negedge n_RST) begin
        if (!n_RST) begin
            adc_data_r <= 16'h0000;
        end else if (!n_CS && !n_RD) begin
            if (AB_n) begin
                adc_data_r <= res_a_r;
            end else begin
                adc_data_r <= res_b_r;
            end
        end else begin
            adc_data_r <= 16'h0000;
        end
    end

    assign n_BUSY        = n_busy_r;
    assign n_EOC         = n_eoc_r;
    assign ADC_DATA      = adc_data_r;
    assign CNVST_IGNORED = cnvst_ignored_r;

endmodule

// File: tb/tb_ad7655_emulator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ad7655_emulator
//
// Self-checking bench for ad7655_emulator with default parameters
// (CONV_CYCLES = 28, EOC_CYCLES = 4). A table of conversion records is run
// in a loop, followed by a hand-written mid-conversion reset sequence.
// When AD7655_EMU_RAMP_EN is defined, the table expects ramp values instead.
// ---------------------------------------------------------------------------
module tb_ad7655_emulator;

    localparam int CONV = 28;
    localparam int EOCC = 4;

    logic        Clk_100M = 1'b0;
    logic        n_RST;
    logic        n_CNVST;
    logic        A0;
    logic        AB_n;
    logic        n_CS;
    logic        n_RD;
    logic [15:0] INA1, INB1, INA2, INB2;
    logic        n_BUSY;
    logic        n_EOC;
    logic [15:0] ADC_DATA;
    logic        CNVST_IGNORED;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ad7655_emulator dut (
        .Clk_100M      (Clk_100M),
        .n_RST         (n_RST),
        .n_CNVST       (n_CNVST),
        .A0            (A0),
        .AB_n          (AB_n),
        .n_CS          (n_CS),
        .n_RD          (n_RD),
        .INA1          (INA1),
        .INB1          (INB1),
        .INA2          (INA2),
        .INB2          (INB2),
        .n_BUSY        (n_BUSY),
        .n_EOC         (n_EOC),
        .ADC_DATA      (ADC_DATA),
        .CNVST_IGNORED (CNVST_IGNORED)
    );

    always #5 Clk_100M = ~Clk_100M;

    typedef struct {
        logic        a0;
        logic [15:0] ina1;
        logic [15:0] inb1;
        logic [15:0] ina2;
        logic [15:0] inb2;
        logic        zero_after;
        logic        inject;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One conversion. Time t counts clock edges after n_CNVST is driven low.
    task automatic run_conv(input vec_t v);
        int  busy_fall = -1;
        int  busy_rise = -1;
        int  eoc1      = -1;
        int  eoc2      = -1;
        int  eoc_cnt   = 0;
        int  ign_cnt   = 0;
        bit  done      = 1'b0;
        logic prev_eoc = 1'b1;
        A0   = v.a0;
        INA1 = v.ina1; INB1 = v.inb1; INA2 = v.ina2; INB2 = v.inb2;
        n_CS = 1'b0; n_RD = 1'b0; AB_n = 1'b1;
        @(posedge Clk_100M); #1;
        n_CNVST = 1'b0;
        for (int t = 1; t <= 200 && !done; t++) begin
            @(posedge Clk_100M); #1;
            if (t == 1) chk("busy_before_detect", int'(n_BUSY), 1);
            if (t == 3 && v.zero_after) begin
                INA1 = 16'h0000; INB1 = 16'h0000; INA2 = 16'h0000; INB2 = 16'h0000;
            end
            if (t == 4) n_CNVST = 1'b1;
            if (v.inject && t == 12) n_CNVST = 1'b0;
            if (v.inject && t == 16) n_CNVST = 1'b1;
            if (n_BUSY == 1'b0 && busy_fall < 0) busy_fall = t;
            if (n_EOC == 1'b0 && prev_eoc == 1'b1) begin
                eoc_cnt++;
                if (eoc_cnt == 1) eoc1 = t;
                if (eoc_cnt == 2) eoc2 = t;
            end
            prev_eoc = n_EOC;
            if (CNVST_IGNORED) ign_cnt++;
            if (eoc_cnt == 1 && t == eoc1 + 1) begin
                chk("data_a", int'(ADC_DATA), int'(v.exp_a));
                AB_n = 1'b0;
            end
            if (eoc_cnt == 2 && t == eoc2 + 1) begin
                chk("data_b", int'(ADC_DATA), int'(v.exp_b));
            end
            if (busy_fall >= 0 && n_BUSY == 1'b1) begin
                busy_rise = t;
                done      = 1'b1;
            end
        end
        chk("busy_fall_time", busy_fall, 2);
        chk("eoc1_time", eoc1, 2 + CONV);
        chk("eoc2_time", eoc2, 2 + 2 * CONV + EOCC);
        chk("busy_rise_time", busy_rise, 2 + 2 * (CONV + EOCC));
        chk("eoc_pulse_count", eoc_cnt, 2);
        chk("ignored_pulses", ign_cnt, v.inject ? 1 : 0);
        // Results persist after the sequence ends.
        AB_n = 1'b1;
        @(posedge Clk_100M); #1;
        chk("hold_a", int'(ADC_DATA), int'(v.exp_a));
        n_RD = 1'b1;
        @(posedge Clk_100M); #1;
        chk("deselected_zero", int'(ADC_DATA), 0);
        repeat (3) @(posedge Clk_100M);
    endtask

    initial begin
        n_RST = 1'b0; n_CNVST = 1'b1; A0 = 1'b0; AB_n = 1'b1;
        n_CS = 1'b1; n_RD = 1'b1;
        INA1 = 16'h0000; INB1 = 16'h0000; INA2 = 16'h0000; INB2 = 16'h0000;

`ifdef AD7655_EMU_RAMP_EN
        vecs[0] = '{1'b0, 16'h1234, 16'hABCD, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 16'h4000};
        vecs[1] = '{1'b0, 16'h1111, 16'h2222, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'h0001, 16'h4001};
        vecs[2] = '{1'b0, 16'h0064, 16'h00C8, 16'h012C, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h4002};
`else
        vecs[0] = '{1'b0, 16'h1234, 16'hABCD, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 16'h1234, 16'hABCD};
        vecs[1] = '{1'b1, 16'h1111, 16'h2222, 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0F0F, 16'hF0F0};
        vecs[2] = '{1'b0, 16'h0064, 16'h00C8, 16'h012C, 16'h0000, 1'b0, 1'b1, 16'h0064, 16'h00C8};
`endif

        repeat (3) @(posedge Clk_100M);
        #1;
        chk("rst_busy", int'(n_BUSY), 1);
        chk("rst_eoc", int'(n_EOC), 1);
        chk("rst_data", int'(ADC_DATA), 0);
        chk("rst_ignored", int'(CNVST_IGNORED), 0);
        n_RST = 1'b1;
        repeat (3) @(posedge Clk_100M);

        for (int i = 0; i < 3; i++) begin
            run_conv(vecs[i]);
        end

        // Reset during EOC_A aborts the conversion immediately.
        begin
            bit found = 1'b0;
            int busy_low = 0;
            int eoc_low  = 0;
            A0 = 1'b0; n_CS = 1'b0; n_RD = 1'b0; AB_n = 1'b1;
            @(posedge Clk_100M); #1;
            n_CNVST = 1'b0;
            for (int t = 1; t <= 100 && !found; t++) begin
                @(posedge Clk_100M); #1;
                if (t == 4) n_CNVST = 1'b1;
                if (n_EOC == 1'b0) found = 1'b1;
            end
            chk("reach_eoc_a", int'(found), 1);
            n_CNVST = 1'b0;
            #1;
            n_RST = 1'b0;
            #1;
            chk("abort_eoc", int'(n_EOC), 1);
            chk("abort_busy", int'(n_BUSY), 1);
            chk("abort_data", int'(ADC_DATA), 0);
            repeat (2) @(posedge Clk_100M);
            #1;
            n_RST = 1'b1;
            for (int t = 0; t < 80; t++) begin
                @(posedge Clk_100M); #1;
                if (n_BUSY == 1'b0) busy_low++;
                if (n_EOC == 1'b0) eoc_low++;
            end
            chk("no_start_after_reset", busy_low, 0);
            chk("no_eoc_after_reset", eoc_low, 0);
            n_CNVST = 1'b1;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
